// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard scancode decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } ps2_state_e;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  // Keyboard status/ack bytes that never carry a key event
  localparam int N_DISCARD = 6;
  localparam logic [7:0] DISCARD_CODES [N_DISCARD] = '{
    8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF
  };

  localparam int KEY_W        = 11;
  localparam int KEY_TOG      = 10;
  localparam int KEY_PRESSED  = 9;
  localparam int KEY_EXT      = 8;
  localparam int KEY_CODE_MSB = 7;

  function automatic logic is_discard(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_DISCARD; i++) begin
      if (code == DISCARD_CODES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a FILTER_LEN-sample persistence filter
// for one PS/2 line; idle/reset level is high.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic line_in,
  output logic line_out
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(FILTER_LEN - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Down-counter reloads on every agreeing sample; level flips on the
  // FILTER_LEN-th consecutive disagreeing sample.
  always_comb begin
    level_d = level_q;
    cnt_d   = RELOAD;
    if (sync2_q != level_q) begin
      if (cnt_q == '0) level_d = sync2_q;
      else             cnt_d   = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= RELOAD;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign line_out = level_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard frame receiver and scancode-set-2 key event decoder.
// Define PS2_WATCHDOG_EN to abort stalled frames after TIMEOUT_CYC cycles.
//
// state  | meaning
// IDLE   | waiting for a start bit (falling clock with data low)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, then decoding the byte
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 24000
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ps2_clk,
  input  logic             ps2_dat,
  output logic [KEY_W-1:0] ps2_key,
  output logic             frame_err,
  output logic             busy
);

  logic clk_f, dat_f, clk_prev_q, fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_sys (clk_sys), .reset_n (reset_n), .line_in (ps2_clk), .line_out (clk_f)
  );
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk_sys (clk_sys), .reset_n (reset_n), .line_in (ps2_dat), .line_out (dat_f)
  );

  assign fall = clk_prev_q & ~clk_f;

  ps2_state_e       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             ext_q, ext_d, brk_q, brk_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             err_q, err_d;

`ifdef PS2_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_expire;

  // A coinciding falling edge takes priority and restarts the count.
  assign wd_expire = (state_q != S_IDLE) && !fall && (wd_cnt_q == WD_W'(TIMEOUT_CYC));

  always_comb begin
    if (fall || state_q == S_IDLE || wd_expire) wd_cnt_d = '0;
    else                                        wd_cnt_d = wd_cnt_q + WD_W'(1);
  end
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYC != 0);
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    key_d     = key_q;
    err_d     = 1'b0;
    if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_f) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shift_d   = {dat_f, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = dat_f;
          state_d  = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_f && (^{shift_q, parity_q})) begin
            if (shift_q == PFX_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == PFX_BRK) begin
              brk_d = 1'b1;
            end else if (shift_q != PFX_PAUSE) begin
              if (!is_discard(shift_q)) key_d = {~key_q[KEY_TOG], ~brk_q, ext_q, shift_q};
              ext_d = 1'b0;
              brk_d = 1'b0;
            end
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
`ifdef PS2_WATCHDOG_EN
    else if (wd_expire) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      key_q      <= '0;
      err_q      <= 1'b0;
`ifdef PS2_WATCHDOG_EN
      wd_cnt_q   <= '0;
`endif
    end else begin
      clk_prev_q <= clk_f;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      key_q      <= key_d;
      err_q      <= err_d;
`ifdef PS2_WATCHDOG_EN
      wd_cnt_q   <= wd_cnt_d;
`endif
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed and randomized frames against a byte-level model of the decoder.
module tb_ps2_key_decoder;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        busy;

  ps2_key_decoder dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .ps2_key   (ps2_key),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  // Observed toggles of ps2_key[10] and frame_err high cycles (outside reset)
  int   tog_seen = 0;
  int   err_seen = 0;
  logic tog_prev = 1'b0;
  always @(posedge clk_sys) begin
    if (reset_n) begin
      if (ps2_key[10] !== tog_prev) tog_seen++;
      if (frame_err === 1'b1) err_seen++;
    end
    tog_prev = ps2_key[10];
  end

  // Byte-level reference model
  logic [10:0] m_key = 11'h000;
  bit          m_ext = 1'b0;
  bit          m_brk = 1'b0;
  int          m_tog = 0;
  int          m_err = 0;
  bit [7:0]    disc [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  function automatic bit in_disc(input bit [7:0] b);
    foreach (disc[i]) if (disc[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_byte(input bit [7:0] b, input bit ok);
    if (!ok) begin
      m_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE1) begin end
    else if (in_disc(b)) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      m_key = {~m_key[10], ~m_brk, m_ext, b};
      m_tog++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_key = 11'h000;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic clock_bit(input bit b);
    ps2_dat = b;
    cyc(10);
    ps2_clk = 1'b0;
    cyc(20);
    ps2_clk = 1'b1;
    cyc(10);
  endtask

  // Key must appear 2 (sync) + 8 (filter) + 1 cycles after the raw stop edge.
  task automatic send_frame(input bit [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit chk_lat);
    logic [10:0] old;
    bit          par;
    par = (~^b) ^ bad_par;
    clock_bit(1'b0);
    for (int i = 0; i < 8; i++) clock_bit(b[i]);
    clock_bit(par);
    old = m_key;
    model_byte(b, !bad_par && !bad_stop);
    ps2_dat = ~bad_stop;
    cyc(10);
    ps2_clk = 1'b0;
    if (chk_lat) begin
      cyc(10);
      check("latency_pre", ps2_key, old);
      cyc(1);
      check("latency_post", ps2_key, m_key);
      cyc(9);
    end else begin
      cyc(20);
    end
    ps2_clk = 1'b1;
    cyc(10);
    ps2_dat = 1'b1;
    cyc(5);
  endtask

  int          tog0;
  int          err0;
  int          n_err_high;
  bit [7:0]    rb;
  bit          rpar, rstop;
  bit [7:0]    pfx [3] = '{8'hE0, 8'hF0, 8'hE1};

  initial begin
    cyc(3);
    check("reset_key", ps2_key, 11'h000);
    check("reset_err", frame_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    reset_n = 1'b1;
    cyc(5);

    // Short low glitch on ps2_clk must not look like a start bit
    ps2_dat = 1'b0;
    cyc(5);
    ps2_clk = 1'b0;
    cyc(3);
    ps2_clk = 1'b1;
    cyc(30);
    check("glitch_busy", busy, 1'b0);
    check("glitch_key", ps2_key, m_key);
    ps2_dat = 1'b1;
    cyc(20);

    send_frame(8'h29, 1'b0, 1'b0, 1'b1);
    check("make_29", ps2_key, 11'h629);
    check("make_29_busy", busy, 1'b0);

    tog0 = tog_seen;
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    check("brk_prefix_key", ps2_key, 11'h629);
    send_frame(8'h29, 1'b0, 1'b0, 1'b1);
    check("break_29", ps2_key, 11'h029);
    check("break_29_tog", tog_seen - tog0, 1);

    tog0 = tog_seen;
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0);
    check("ext_break_75", ps2_key[9:0], 10'h175);
    check("ext_break_75_model", ps2_key, m_key);
    check("ext_break_75_tog", tog_seen - tog0, 1);

    tog0 = tog_seen;
    err0 = err_seen;
    send_frame(8'h29, 1'b1, 1'b0, 1'b1);
    check("parity_err_cnt", err_seen - err0, 1);
    check("parity_err_key", ps2_key, 11'h575);
    check("parity_err_tog", tog_seen - tog0, 0);

    // Reset in the middle of a frame
    clock_bit(1'b0);
    clock_bit(1'b1);
    clock_bit(1'b0);
    clock_bit(1'b1);
    check("midframe_busy", busy, 1'b1);
    err0 = err_seen;
    @(posedge clk_sys);
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_key", ps2_key, 11'h000);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_err", frame_err, 1'b0);
    model_reset();
    cyc(3);
    reset_n = 1'b1;
    ps2_dat = 1'b1;
    cyc(20);
    check("midframe_no_err", err_seen - err0, 0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check("after_rst_1c", ps2_key, 11'h61C);

    // Stalled partial frame with prefixes pending
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    clock_bit(1'b0);
    for (int i = 0; i < 4; i++) clock_bit(i[0]);
    check("stall_busy", busy, 1'b1);
    err0 = err_seen;
`ifdef PS2_WATCHDOG_EN
    cyc(24001);
    check("wd_err", err_seen - err0, 1);
    check("wd_busy", busy, 1'b0);
    model_byte(8'h00, 1'b0);
    ps2_dat = 1'b1;
    cyc(10);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check("wd_then_1c", ps2_key[9:0], 10'h21C);
`else
    cyc(25000);
    check("no_wd_busy", busy, 1'b1);
    check("no_wd_err", err_seen - err0, 0);
    reset_n = 1'b0;
    model_reset();
    cyc(3);
    reset_n = 1'b1;
    ps2_dat = 1'b1;
    cyc(20);
`endif

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    rb = pfx[$urandom_range(0, 2)];
        2:       rb = disc[$urandom_range(0, 5)];
        default: rb = 8'($urandom_range(0, 255));
      endcase
      rpar  = ($urandom_range(0, 9) == 0);
      rstop = !rpar && ($urandom_range(0, 19) == 0);
      send_frame(rb, rpar, rstop, (n % 8) == 0);
      check("rand_key", ps2_key, m_key);
      check("rand_busy", busy, 1'b0);
    end

    n_err_high = err_seen;
    check("total_toggles", tog_seen, m_tog);
    check("total_err_pulses", n_err_high, m_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 8: consecutive identical clk_sys samples needed to accept a PS/2 line level change.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 24000: idle clk_sys cycles (2 ms at 12 MHz) before a partial frame is aborted.
REQ-003 The block SHALL have port clk_sys  input  1  system clock, sole clock domain.
REQ-004 The block SHALL have port reset_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 The block SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous.
REQ-006 The block SHALL have port ps2_dat  input  1  raw PS/2 data line, asynchronous.
REQ-007 The block SHALL have port ps2_key  output  11  key event: [10] toggle strobe, [9] pressed, [8] extended (E0), [7:0] scancode.
REQ-008 The block SHALL have port frame_err  output  1  one-cycle pulse on a rejected or aborted frame.
REQ-009 The block SHALL have port busy  output  1  high while a frame is in progress (state not IDLE).

Function
REQ-010 Each PS/2 line SHALL pass through a 2-FF synchronizer, then a filter; the filtered level changes only after FILTER_LEN consecutive equal samples.
REQ-011 A bit SHALL be sampled from filtered ps2_dat on the clk_sys cycle the filtered ps2_clk falls from 1 to 0.
REQ-012 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-013 The IDLE state SHALL behave as follows: falling edge with dat=0 goes to DATA with bit count 0; dat=1 stays in IDLE.
REQ-014 The DATA state SHALL shift bits LSB first, and after the 8th bit go to PARITY.
REQ-015 The PARITY state SHALL store the bit and then go to STOP.
REQ-016 The STOP state SHALL accept the byte when dat=1 and the 9 bits (data plus parity) contain an odd number of ones; otherwise it SHALL pulse frame_err. Both cases return to IDLE.
REQ-017 An accepted 0xE0 byte SHALL set the ext flag, and an accepted 0xF0 byte SHALL set the brk flag; neither emits an event.
REQ-018 An accepted 0xE1 byte SHALL be discarded, with ext and brk unchanged.
REQ-019 Accepted bytes 0x00, 0xAA, 0xEE, 0xFA, 0xFE or 0xFF SHALL be discarded, and ext and brk cleared.
REQ-020 Any other accepted byte SHALL set ps2_key to {~ps2_key[10], ~brk, ext, byte} and then clear ext and brk.
REQ-021 ps2_key SHALL update exactly 1 clk_sys cycle after the stop-bit falling edge, and [10] SHALL toggle exactly once per emitted event.
REQ-022 A frame_err pulse SHALL clear ext and brk, and ps2_key SHALL be unchanged.
REQ-023 If a falling edge and watchdog expiry coincide, the edge SHALL win and the watchdog counter restart.

Reset
REQ-024 Asserting reset_n low SHALL immediately force: FSM to IDLE, ps2_key=0, frame_err=0, busy=0, ext=brk=0, filters to level 1, and watchdog counter to 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial byte with no event and no frame_err.

Configuration
REQ-026 With macro PS2_WATCHDOG_EN defined, a counter SHALL count clk_sys cycles since the last falling edge while not IDLE.
REQ-027 On reaching TIMEOUT_CYC, the FSM SHALL return to IDLE, frame_err SHALL pulse, and ext and brk SHALL clear.
REQ-028 Without PS2_WATCHDOG_EN, no counter SHALL exist and a stalled frame is left only by further edges or reset; TIMEOUT_CYC is ignored.

Structure
REQ-029 Package ps2_pkg SHALL hold:
- the FSM state enum;
- prefix constants (0xE0, 0xF0, 0xE1);
- the discard-code list;
- ps2_key field index constants.
REQ-030 A sub-module ps2_line_filter (synchronizer plus FILTER_LEN filter, 1-bit) SHALL be instantiated once per line.

Verification
REQ-031 Frame 0x29 with parity 0 and stop 1 SHALL give, 1 cycle after the stop edge, ps2_key 0x000 -> {1,1,0,0x29} = 0x629.
REQ-032 Frames F0,29 after REQ-031 SHALL give ps2_key = 0x029 ([10]=0, pressed 0), with exactly one toggle across both bytes.
REQ-033 Frames E0,F0,75 SHALL give ps2_key[9:0] = {0,1,0x75}, with one toggle.
REQ-034 Frame 0x29 with parity 1 SHALL give a one-cycle frame_err pulse, ps2_key unchanged, and no toggle.
REQ-035 With PS2_WATCHDOG_EN: start bit plus 4 bits, then ps2_clk held high for 24001 cycles, SHALL give a frame_err pulse and busy=0; a following 0x1C frame SHALL decode to ps2_key[9:0] = {1,0,0x1C}.
REQ-036 A 3-cycle low glitch on ps2_clk with FILTER_LEN=8 SHALL sample no bit: busy stays 0 and ps2_key is unchanged.
